// File: rtl/serial_word_packer_pkg.sv
// Shared types and constants for the serial word packer and the downstream reversal stage.
package serial_pack_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_STALL = 2'd2
  } pack_state_t;

  // Word width shared with the bit-reversal stage.
  localparam int PACK_WIDTH = 100;

endpackage

// File: rtl/serial_word_packer_hold.sv
// Output word register with valid/ready: loads a completed word, holds it stable until taken.
module word_hold_reg
  import serial_pack_pkg::*;
#(
  parameter int WIDTH = PACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_word,
  output logic             m_valid,
  output logic             drain
);

  logic [WIDTH-1:0] word_reg, word_next;
  logic             valid_reg, valid_next;

  assign drain = valid_reg & m_ready;

  // A load in the same cycle as a drain keeps valid high with the new word.
  always_comb begin
    word_next  = word_reg;
    valid_next = valid_reg;
    if (load) begin
      word_next  = load_word;
      valid_next = 1'b1;
    end else if (drain) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      word_reg  <= word_next;
      valid_reg <= valid_next;
    end
  end

  assign m_word  = word_reg;
  assign m_valid = valid_reg;

endmodule

// File: rtl/serial_word_packer.sv
// Serial-to-parallel packer: 1-bit stream in, WIDTH-bit words out over valid/ready, double buffered.
// Define PACK_LSB_FIRST_EN to place the first accepted bit in m_word[0] instead of m_word[WIDTH-1].
module serial_word_packer
  import serial_pack_pkg::*;
#(
  parameter  int WIDTH = PACK_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_flush,
  output logic [WIDTH-1:0] m_word,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] bit_count
);

  // The shift register never holds more than WIDTH-1 bits; the last bit goes straight to the output.
  pack_state_t        state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [WIDTH-2:0]   shift_reg, shift_next;
  logic [WIDTH-2:0]   shift_moved;
  logic [WIDTH-1:0]   full_word;
  logic               at_last;
  logic               out_blocked;
  logic               accept;
  logic               complete;
  logic               drain;

  assign at_last     = (count_reg == CNT_W'(WIDTH - 1));
  assign out_blocked = m_valid & ~m_ready;
  assign s_ready     = ~rst & ~s_flush & (state_reg != S_STALL) & ~(at_last & out_blocked);
  assign accept      = s_valid & s_ready;
  assign complete    = accept & at_last;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
`ifdef PACK_LSB_FIRST_EN
      if (gi == WIDTH - 2) begin : g_top
        assign shift_moved[gi] = s_bit;
      end else begin : g_mid
        assign shift_moved[gi] = shift_reg[gi+1];
      end
`else
      if (gi == 0) begin : g_bot
        assign shift_moved[gi] = s_bit;
      end else begin : g_mid
        assign shift_moved[gi] = shift_reg[gi-1];
      end
`endif
    end
  endgenerate

`ifdef PACK_LSB_FIRST_EN
  assign full_word = {s_bit, shift_reg};
`else
  assign full_word = {shift_reg, s_bit};
`endif

  always_comb begin
    count_next = count_reg;
    shift_next = shift_reg;
    if (s_flush || complete) begin
      count_next = '0;
      shift_next = '0;
    end else if (accept) begin
      count_next = count_reg + CNT_W'(1);
      shift_next = shift_moved;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (s_flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) state_next = S_FILL;
        end
        S_FILL: begin
          if (complete)                       state_next = S_IDLE;
          else if (at_last && out_blocked)    state_next = S_STALL;
        end
        S_STALL: begin
          if (drain || !m_valid) state_next = S_FILL;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (complete),
    .load_word(full_word),
    .m_ready  (m_ready),
    .m_word   (m_word),
    .m_valid  (m_valid),
    .drain    (drain)
  );

  assign bit_count = count_reg;

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed bench for serial_word_packer: an 8-bit instance for handshake corners, a 100-bit instance.
module tb_serial_word_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s_bit8, s_valid8, s_ready8, s_flush8, m_valid8, m_ready8;
  logic [7:0] m_word8;
  logic [3:0] count8;

  logic         s_bit100, s_valid100, s_ready100, s_flush100, m_valid100, m_ready100;
  logic [99:0]  m_word100;
  logic [6:0]   count100;

  serial_word_packer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .s_bit(s_bit8), .s_valid(s_valid8), .s_ready(s_ready8),
    .s_flush(s_flush8), .m_word(m_word8), .m_valid(m_valid8), .m_ready(m_ready8),
    .bit_count(count8)
  );

  serial_word_packer #(.WIDTH(100)) dut100 (
    .clk(clk), .rst(rst), .s_bit(s_bit100), .s_valid(s_valid100), .s_ready(s_ready100),
    .s_flush(s_flush100), .m_word(m_word100), .m_valid(m_valid100), .m_ready(m_ready100),
    .bit_count(count100)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic bit8(input logic [7:0] w, input int i);
`ifdef PACK_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  function automatic logic bit100(input logic [99:0] w, input int i);
`ifdef PACK_LSB_FIRST_EN
    return w[i];
`else
    return w[99-i];
`endif
  endfunction

  typedef struct packed {
    logic       s_valid;
    logic       s_bit;
    logic       s_flush;
    logic       m_ready;
    logic       exp_s_ready;
    logic       exp_m_valid;
    logic       chk_word;
    logic [3:0] exp_count;
    logic [7:0] exp_word;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic b, input logic f, input logic r,
                              input logic es, input logic em, input logic cw,
                              input logic [3:0] ec, input logic [7:0] ew);
    vec_t x;
    x.s_valid = v; x.s_bit = b; x.s_flush = f; x.m_ready = r;
    x.exp_s_ready = es; x.exp_m_valid = em; x.chk_word = cw;
    x.exp_count = ec; x.exp_word = ew;
    return x;
  endfunction

  vec_t vecs[10];

  initial begin
    logic [7:0]  stream;
    logic [7:0]  exp_pack;
    logic [7:0]  word1, word2;
    logic [99:0] w100;
    logic        all_ready;

    stream = 8'b1011_0010;
`ifdef PACK_LSB_FIRST_EN
    exp_pack = 8'h4D;
`else
    exp_pack = 8'hB2;
`endif
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(1'b1, stream[7-k], 1'b0, 1'b1, 1'b1, 1'b0, (k == 0), 4'(k), 8'h00);
    vecs[8] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, exp_pack);
    vecs[9] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);

    // Reset with s_valid held high
    rst = 1'b1;
    s_bit8 = 1'b1; s_valid8 = 1'b1; s_flush8 = 1'b0; m_ready8 = 1'b0;
    s_bit100 = 1'b1; s_valid100 = 1'b1; s_flush100 = 1'b0; m_ready100 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_s_ready8", s_ready8, 1'b0);
      chk("rst_s_ready100", s_ready100, 1'b0);
      if (i > 0) begin
        chk("rst_m_valid8", m_valid8, 1'b0);
        chk("rst_m_word8", m_word8, 8'h00);
        chk("rst_count8", count8, 4'd0);
        chk("rst_m_valid100", m_valid100, 1'b0);
        chk("rst_m_word100", m_word100, 100'h0);
        chk("rst_count100", count100, 7'd0);
      end
      tick();
    end
    rst = 1'b0;
    s_valid8 = 1'b0; s_valid100 = 1'b0;

    // Table: 8-bit stream 1,0,1,1,0,0,1,0 with m_ready high
    for (int k = 0; k < 10; k++) begin
      s_valid8 = vecs[k].s_valid; s_bit8 = vecs[k].s_bit;
      s_flush8 = vecs[k].s_flush; m_ready8 = vecs[k].m_ready;
      #1;
      chk("tbl_s_ready", s_ready8, vecs[k].exp_s_ready);
      chk("tbl_m_valid", m_valid8, vecs[k].exp_m_valid);
      chk("tbl_count", count8, vecs[k].exp_count);
      if (vecs[k].chk_word) chk("tbl_m_word", m_word8, vecs[k].exp_word);
      tick();
    end

    // Back-pressure: 15 bits with m_ready low, then drain and the 16th bit
    word1 = 8'hA5; word2 = 8'h3C;
    m_ready8 = 1'b0; s_valid8 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_bit8 = (i < 8) ? bit8(word1, i) : bit8(word2, i - 8);
      #1;
      chk("stall_fill_s_ready", s_ready8, 1'b1);
      if (i == 8) begin
        chk("stall_word1_valid", m_valid8, 1'b1);
        chk("stall_word1", m_word8, word1);
      end
      tick();
    end
    s_bit8 = bit8(word2, 7);
    #1;
    chk("stall_last_s_ready", s_ready8, 1'b0);
    chk("stall_last_count", count8, 4'd7);
    tick();
    m_ready8 = 1'b1;
    #1;
    chk("stall_state_s_ready", s_ready8, 1'b0);
    chk("stall_held_word", m_word8, word1);
    chk("stall_held_valid", m_valid8, 1'b1);
    tick();
    #1;
    chk("stall_drained_valid", m_valid8, 1'b0);
    chk("stall_resume_s_ready", s_ready8, 1'b1);
    chk("stall_resume_count", count8, 4'd7);
    tick();
    s_valid8 = 1'b0;
    #1;
    chk("stall_word2_valid", m_valid8, 1'b1);
    chk("stall_word2", m_word8, word2);
    chk("stall_word2_count", count8, 4'd0);
    tick();
    #1;
    chk("stall_word2_taken", m_valid8, 1'b0);

    // Flush after 5 bits, then 8 ones
    s_valid8 = 1'b1; s_bit8 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    s_flush8 = 1'b1; s_bit8 = 1'b1;
    #1;
    chk("flush_count_before", count8, 4'd5);
    chk("flush_s_ready", s_ready8, 1'b0);
    tick();
    s_flush8 = 1'b0;
    #1;
    chk("flush_count_after", count8, 4'd0);
    chk("flush_m_valid", m_valid8, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    s_valid8 = 1'b0;
    #1;
    chk("flush_word_valid", m_valid8, 1'b1);
    chk("flush_word", m_word8, 8'hFF);
    tick();

    // 100-bit word, sustained with m_ready high
    w100 = 100'h1010101010101010101010111;
    m_ready100 = 1'b1; s_valid100 = 1'b1;
    all_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_bit100 = bit100(w100, i);
      #1;
      all_ready &= s_ready100;
      tick();
    end
    s_valid100 = 1'b0;
    #1;
    chk("w100_s_ready_sustained", all_ready, 1'b1);
    chk("w100_valid", m_valid100, 1'b1);
    chk("w100_word", m_word100, w100);
    tick();

    // Reset mid-word, then a clean word
    s_valid100 = 1'b1; s_bit100 = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    #1;
    chk("w100_mid_count", count100, 7'd40);
    rst = 1'b1;
    #1;
    chk("w100_rst_s_ready", s_ready100, 1'b0);
    tick();
    rst = 1'b0; s_valid100 = 1'b0;
    #1;
    chk("w100_post_rst_count", count100, 7'd0);
    chk("w100_post_rst_valid", m_valid100, 1'b0);
    s_valid100 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_bit100 = bit100(w100, i);
      tick();
    end
    s_valid100 = 1'b0;
    #1;
    chk("w100_clean_valid", m_valid100, 1'b1);
    chk("w100_clean_word", m_word100, w100);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
